// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider (Abus / Bbus) using restoring
// division, one quotient bit per clock, fixed latency, truncation rounding.
module fp_div_seq #(
    parameter int BIAS  = 127,
    parameter int QBITS = 25
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_startFP,
    input  logic [31:0] i_Abus,
    input  logic [31:0] i_Bbus,
    output logic [31:0] o_ResultBus,
    output logic        o_doneFP
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        LOAD,
        DIV,
        NORM
    } state_t;

    state_t r_state;
    state_t w_nextState;

    // Only sign and exponent of each operand are needed after LOAD
    logic [8:0]       r_aHead;
    logic [8:0]       r_bHead;
    logic [25:0]      r_rem;
    logic [23:0]      r_divisor;
    logic [QBITS-1:0] r_quot;
    logic [4:0]       r_cnt;
    logic [31:0]      r_result;

    logic        w_remGe;
    logic [25:0] w_remSub;
    logic [25:0] w_remNext;
    logic        w_sign;
    logic [9:0]  w_exp;
    logic [22:0] w_mant;
    logic        w_aZero;
    logic        w_bZero;
    logic [31:0] w_normResult;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (i_startFP) w_nextState = INIT;
            INIT:    if (!i_startFP) w_nextState = LOAD;
            LOAD:    w_nextState = DIV;
            DIV:     if (r_cnt == 5'd0) w_nextState = NORM;
            NORM:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    assign w_remGe   = (r_rem >= {2'b00, r_divisor});
    assign w_remSub  = w_remGe ? (r_rem - {2'b00, r_divisor}) : r_rem;
    assign w_remNext = w_remSub << 1;

    // Exponent is kept 10 bits wide so overflow and underflow stay distinguishable
    assign w_sign  = r_aHead[8] ^ r_bHead[8];
    assign w_exp   = {2'b00, r_aHead[7:0]} - {2'b00, r_bHead[7:0]}
                   + 10'(BIAS - 1) + {9'd0, r_quot[QBITS-1]};
    assign w_mant  = r_quot[QBITS-1] ? r_quot[QBITS-2:1] : r_quot[QBITS-3:0];
    assign w_aZero = (r_aHead[7:0] == 8'd0);
    assign w_bZero = (r_bHead[7:0] == 8'd0);

    always_comb begin
        w_normResult = {w_sign, w_exp[7:0], w_mant};
        if (w_bZero && w_aZero) begin
            w_normResult = 32'h7FC0_0000;
        end else if (w_bZero) begin
            w_normResult = {w_sign, 8'hFF, 23'd0};
        end else if (w_aZero) begin
            w_normResult = {w_sign, 31'd0};
        end else if ($signed(w_exp) >= 10'sd255) begin
            w_normResult = {w_sign, 8'hFF, 23'd0};
        end else if ($signed(w_exp) <= 10'sd0) begin
            w_normResult = {w_sign, 31'd0};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_aHead   <= '0;
            r_bHead   <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_quot    <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_aHead   <= i_Abus[31:23];
                    r_bHead   <= i_Bbus[31:23];
                    r_rem     <= {2'b00, 1'b1, i_Abus[22:0]};
                    r_divisor <= {1'b1, i_Bbus[22:0]};
                    r_quot    <= '0;
                    r_cnt     <= 5'(QBITS - 1);
                end
                DIV: begin
                    r_rem  <= w_remNext;
                    r_quot <= {r_quot[QBITS-2:0], w_remGe};
                    r_cnt  <= r_cnt - 5'd1;
                end
                NORM: begin
                    r_result <= w_normResult;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_ResultBus = r_result;
    assign o_doneFP    = (r_state == IDLE);

endmodule
